// File: rtl/booth_sched_pkg.sv
// Shared types and defaults for the Booth multiplier scheduler.
package booth_sched_pkg;

    // Scheduler FSM states, in service order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int DEF_W          = 16;
    localparam int DEF_MUL_CYCLES = 18;

    // Width of a counter that must hold 0..cycles-1 (never narrower than one bit).
    function automatic int cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_MUL_CYCLES);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after
// rr_ptr (wrapping) wins. Produces a one-hot winner and its index.
module rr_arbiter
    import booth_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        win     = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = IDX_W'((32'(rr_ptr) + 32'(i)) % 32'(NREQ));
            if (!found_s && req[cand_s]) begin
                found_s     = 1'b1;
                win[cand_s] = 1'b1;
                idx         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/booth_mult_sched.sv
// Round-robin scheduler sharing one serial-load Booth multiplier between
// NREQ requesters: grant, load A then B, time the fixed latency, capture
// the product and pulse done to the granted requester.
module booth_mult_sched
    import booth_sched_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int W          = DEF_W,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   op_a,
    input  logic [NREQ*W-1:0]   op_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [2*W-1:0]      prod,
    output logic                busy,
    output logic                mul_start,
    output logic [W-1:0]        mul_data,
    input  logic [2*W-1:0]      mul_result
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW    = cnt_w(MUL_CYCLES);

    state_t           state_r, state_nxt;
    logic [IDX_W-1:0] rr_ptr_r, rr_ptr_nxt;
    logic [IDX_W-1:0] idx_r, idx_nxt;
    logic [W-1:0]     a_r, a_nxt;
    logic [W-1:0]     b_r, b_nxt;
    logic [CW-1:0]    cnt_r, cnt_nxt;
    logic [2*W-1:0]   prod_nxt;
    logic [NREQ-1:0]  gnt_nxt, done_nxt;
    logic             busy_nxt, mul_start_nxt;
    logic [W-1:0]     mul_data_nxt;

    logic [NREQ-1:0]  arb_win_s;
    logic [IDX_W-1:0] arb_idx_s;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .win    (arb_win_s),
        .idx    (arb_idx_s)
    );

    // Next-state, job context and next values of the registered outputs.
    always_comb begin
        state_nxt  = state_r;
        rr_ptr_nxt = rr_ptr_r;
        idx_nxt    = idx_r;
        a_nxt      = a_r;
        b_nxt      = b_r;
        cnt_nxt    = cnt_r;
        prod_nxt   = prod;

        case (state_r)
            IDLE: begin
                if (|arb_win_s) begin
                    idx_nxt   = arb_idx_s;
                    a_nxt     = op_a[arb_idx_s*W +: W];
                    b_nxt     = op_b[arb_idx_s*W +: W];
                    state_nxt = LOAD_A;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOAD_A: begin
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Hold the count at its terminal value rather than wrapping.
                if (cnt_r == CW'(MUL_CYCLES - 1)) begin
                    prod_nxt  = mul_result;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt   = cnt_r + CW'(1);
                    state_nxt = WAIT;
                end
            end
            RESP: begin
                rr_ptr_nxt = (idx_r == IDX_W'(NREQ - 1)) ? '0 : idx_r + IDX_W'(1);
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered.
        gnt_nxt       = '0;
        done_nxt      = '0;
        mul_start_nxt = 1'b0;
        mul_data_nxt  = '0;
        case (state_nxt)
            LOAD_A: begin
                gnt_nxt       = onehot(idx_nxt);
                mul_start_nxt = 1'b1;
                mul_data_nxt  = a_nxt;
            end
            LOAD_B: begin
                gnt_nxt       = onehot(idx_nxt);
                mul_start_nxt = 1'b1;
                mul_data_nxt  = b_nxt;
            end
            WAIT: begin
                gnt_nxt = onehot(idx_nxt);
            end
            RESP: begin
                gnt_nxt  = onehot(idx_nxt);
                done_nxt = onehot(idx_nxt);
            end
            default: begin
                gnt_nxt = '0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State, job context and registered outputs; reset abandons any job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            idx_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cnt_r     <= '0;
            prod      <= '0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_data  <= '0;
        end else begin
            state_r   <= state_nxt;
            rr_ptr_r  <= rr_ptr_nxt;
            idx_r     <= idx_nxt;
            a_r       <= a_nxt;
            b_r       <= b_nxt;
            cnt_r     <= cnt_nxt;
            prod      <= prod_nxt;
            gnt       <= gnt_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            mul_start <= mul_start_nxt;
            mul_data  <= mul_data_nxt;
        end
    end

endmodule

// File: tb/tb_booth_mult_sched.sv
// Self-checking bench for booth_mult_sched with a behavioural serial-load
// multiplier and a job-level round-robin/product reference model.
module tb_booth_mult_sched;

    localparam int NREQ = 3;
    localparam int W    = 16;
    localparam int MC   = 18;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   op_a, op_b;
    logic [NREQ-1:0]     gnt, done;
    logic [2*W-1:0]      prod;
    logic                busy, mul_start;
    logic [W-1:0]        mul_data;
    logic [2*W-1:0]      mul_result;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: round-robin pointer and last returned product.
    int             rr_model  = 0;
    logic [2*W-1:0] last_prod = '0;

    always #5 clk = ~clk;

    booth_mult_sched #(.NREQ(NREQ), .W(W), .MUL_CYCLES(MC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .gnt        (gnt),
        .done       (done),
        .prod       (prod),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_data   (mul_data),
        .mul_result (mul_result)
    );

    // Behavioural multiplier: first start cycle loads A, the following one
    // loads B; the product is valid MC cycles after the B-load cycle.
    logic                  m_prev_start = 1'b0;
    logic [W-1:0]          m_a = '0, m_b = '0;
    logic                  m_valid = 1'b0;
    int                    m_age = 0;
    logic signed [2*W-1:0] m_prod;

    always @(posedge clk) begin
        m_prev_start <= mul_start;
        if (mul_start && !m_prev_start) begin
            m_a     <= mul_data;
            m_valid <= 1'b0;
        end else if (mul_start && m_prev_start) begin
            m_b     <= mul_data;
            m_valid <= 1'b1;
            m_age   <= 0;
        end else if (m_valid) begin
            m_age <= m_age + 1;
        end
    end

    assign m_prod     = $signed(m_a) * $signed(m_b);
    assign mul_result = (m_valid && m_age >= MC - 1) ? m_prod : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr_model + k) % NREQ]) return (rr_model + k) % NREQ;
        end
        return -1;
    endfunction

    // Serve one job; req must already be set while the DUT sits in IDLE.
    task automatic serve(input bit mutate, input bit drop, input bit keep, output int obs_win);
        int                    win, lat, wcnt;
        logic [W-1:0]          ea, eb;
        logic signed [2*W-1:0] sa, sb;
        logic [2*W-1:0]        ep;
        logic [NREQ-1:0]       exp_g;
        bit                    gnt_ok, quiet_ok, hold_ok;
        win = rr_pick(req);
        if (win < 0) win = 0;
        ea = op_a[win*W +: W];
        eb = op_b[win*W +: W];
        sa = $signed(ea);
        sb = $signed(eb);
        ep = sa * sb;
        exp_g = '0;
        exp_g[win] = 1'b1;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == '0 && lat < 10);
        obs_win = -1;
        for (int k = 0; k < NREQ; k++) if (gnt[k]) obs_win = k;
        check("grant_latency", lat, 1);
        check("gnt_load_a", gnt, exp_g);
        check("busy_load_a", busy, 1'b1);
        check("start_load_a", mul_start, 1'b1);
        check("data_load_a", mul_data, ea);
        check("prod_hold_grant", prod, last_prod);

        @(negedge clk);
        check("gnt_load_b", gnt, exp_g);
        check("start_load_b", mul_start, 1'b1);
        check("data_load_b", mul_data, eb);

        wcnt = 0; gnt_ok = 1; quiet_ok = 1; hold_ok = 1;
        do begin
            @(negedge clk);
            wcnt++;
            if (done == '0) begin
                if (gnt !== exp_g || busy !== 1'b1) gnt_ok = 0;
                if (mul_start !== 1'b0 || mul_data !== '0) quiet_ok = 0;
                if (prod !== last_prod) hold_ok = 0;
            end
            if (drop && wcnt == 4) req[win] = 1'b0;
            if (mutate && wcnt == 5) begin
                op_a[win*W +: W] = ~ea;
                op_b[win*W +: W] = ea ^ 16'h5A5A;
            end
        end while (done == '0 && wcnt < 60);
        check("done_latency", wcnt, MC + 1);
        check("gnt_wait_stable", gnt_ok, 1'b1);
        check("mul_quiet_wait", quiet_ok, 1'b1);
        check("prod_hold_wait", hold_ok, 1'b1);
        check("done_onehot", done, exp_g);
        check("gnt_resp", gnt, exp_g);
        check("prod_value", prod, ep);
        if (!keep) req[win] = 1'b0;

        @(negedge clk);
        check("done_pulse_end", done, '0);
        check("gnt_idle", gnt, '0);
        check("busy_idle", busy, 1'b0);
        check("prod_held_idle", prod, ep);
        last_prod = ep;
        rr_model  = (win + 1) % NREQ;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        rr_model  = 0;
        last_prod = '0;
    endtask

    int w;
    int order [4];

    initial begin
        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, '0);
        check("rst_done", done, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_start", mul_start, 1'b0);
        check("rst_data", mul_data, '0);
        check("rst_prod", prod, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single job: -10 x 13.
        op_a[0 +: W] = 16'hFFF6;
        op_b[0 +: W] = 16'h000D;
        req = 3'b001;
        serve(1'b0, 1'b0, 1'b0, w);
        check("single_prod_const", prod, 32'hFFFF_FF7E);

        // Simultaneous requests after reset: req0 first, then req1.
        do_reset();
        op_a[0 +: W] = 16'd3;      op_b[0 +: W] = 16'd4;
        op_a[W +: W] = 16'hFFF9;   op_b[W +: W] = 16'hFFF7;
        req = 3'b011;
        serve(1'b0, 1'b0, 1'b0, w);
        check("simul_first_win", w, 0);
        check("simul_first_prod", prod, 32'd12);
        serve(1'b0, 1'b0, 1'b0, w);
        check("simul_second_win", w, 1);
        check("simul_second_prod", prod, 32'd63);

        // Fairness: req0 and req1 held for four jobs.
        do_reset();
        req = 3'b011;
        for (int j = 0; j < 4; j++) serve(1'b0, 1'b0, 1'b1, order[j]);
        req = '0;
        check("fair_0", order[0], 0);
        check("fair_1", order[1], 1);
        check("fair_2", order[2], 0);
        check("fair_3", order[3], 1);

        // Corner operands.
        op_a[2*W +: W] = 16'h8000; op_b[2*W +: W] = 16'h8000;
        req = 3'b100;
        serve(1'b0, 1'b0, 1'b0, w);
        check("corner_min_min", prod, 32'h4000_0000);
        op_a[2*W +: W] = 16'h7FFF; op_b[2*W +: W] = 16'h8000;
        req = 3'b100;
        serve(1'b0, 1'b0, 1'b0, w);
        check("corner_max_min", prod, 32'hC000_8000);

        // Operand change and req drop during WAIT must not disturb the job.
        op_a[0 +: W] = 16'd1234; op_b[0 +: W] = 16'hFF00;
        req = 3'b001;
        serve(1'b1, 1'b1, 1'b1, w);

        // Reset at cycle 8 of a job: everything clears at once, no done.
        op_a[0 +: W] = 16'd77; op_b[0 +: W] = 16'd5;
        req = 3'b001;
        @(negedge clk);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", gnt, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_start", mul_start, 1'b0);
        check("midrst_data", mul_data, '0);
        check("midrst_prod", prod, '0);
        begin
            bit quiet;
            quiet = 1;
            repeat (3) begin
                @(negedge clk);
                if (done !== '0) quiet = 0;
            end
            check("midrst_no_done", quiet, 1'b1);
        end
        req = 3'b010;
        op_a[W +: W] = 16'hFF9C; op_b[W +: W] = 16'd321;
        rst_n     = 1'b1;
        rr_model  = 0;
        last_prod = '0;
        serve(1'b0, 1'b0, 1'b0, w);
        check("post_rst_win", w, 1);

        // Randomised traffic against the reference model.
        for (int j = 0; j < 24; j++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req[k]) begin
                    op_a[k*W +: W] = W'($urandom);
                    op_b[k*W +: W] = W'($urandom);
                end
            end
            req = req | NREQ'($urandom_range(1, (1 << NREQ) - 1));
            serve(bit'($urandom_range(0, 1)), 1'b0, bit'($urandom_range(0, 1)), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mult_sched.md
# booth_mult_sched

Round-robin scheduler that shares one serial-load Booth multiplier (operands loaded one after another over a single 16-bit `data_in` bus after `start`) between `NREQ` requesters. It arbitrates pending requests and sequences the multiplier's load protocol, A then B. It times the fixed multiplication latency, captures the 32-bit product and returns it to the granted requester with a one-cycle `done` pulse. It sits between the requesting datapaths and the multiplier's `start`/`data_in`/`result` pins.

## Interface
- `NREQ`, 2, number of requesters (2..8)
- `W`, 16, operand width; product is `2*W`
- `MUL_CYCLES`, 18, cycles from the B-load cycle until the multiplier's `result` is valid
- `clk`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester request, level, held until own `done`
- `op_a`  in  NREQ*W  packed multiplicands, slice i = requester i, two's complement
- `op_b`  in  NREQ*W  packed multipliers, slice i = requester i
- `gnt`  out  NREQ  one-hot grant, high from LOAD_A through RESP
- `done`  out  NREQ  one-cycle pulse to granted requester, in RESP
- `prod`  out  2*W  product of last completed job, held until next RESP
- `busy`  out  1  high in any state except IDLE
- `mul_start`  out  1  to multiplier `start`
- `mul_data`  out  W  to multiplier `data_in`
- `mul_result`  in  2*W  from multiplier `result`

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE: if any `req` is set, pick a winner by round-robin from `rr_ptr`. Latch the winner index and its `op_a`/`op_b` into internal registers. Go to LOAD_A. Otherwise stay in IDLE.
- LOAD_A: `mul_start`=1, `mul_data`=latched A. Go to LOAD_B.
- LOAD_B: `mul_start`=1, `mul_data`=latched B. Clear `cnt` to 0. Go to WAIT.
- WAIT: `mul_start`=0, `mul_data`=0. Increment `cnt` each cycle. When `cnt`==MUL_CYCLES-1, capture `mul_result` into `prod` and go to RESP.
- RESP: `done[idx]`=1 for this cycle only. Set `rr_ptr` = (idx+1) mod NREQ. Go to IDLE.
- Round-robin rule: search for the first set `req` starting at `rr_ptr` and wrapping. After reset `rr_ptr`=0, so requester 0 has top priority.
- Operands are sampled only at the IDLE grant edge. Later changes to `op_a`/`op_b` have no effect on the job in progress.
- If `req` is dropped mid-service, the job still completes and `done` still pulses. `gnt` is never revoked early.
- A requester whose `req` is still high in the cycle after RESP is treated as a new request and competes normally. A continuously-held `req` from two requesters therefore alternates.
- `prod` is the raw `mul_result`. No sign extension or saturation is applied; the multiplier delivers a full 2W-bit signed product.

## Timing
- Reset (async assert): state=IDLE, `rr_ptr`=0, `cnt`=0, `gnt`=0, `done`=0, `busy`=0, `mul_start`=0, `mul_data`=0, `prod`=0.
- Reset asserted mid-job: the job is abandoned and no `done` is issued. The multiplier has no reset of its own; the next LOAD_A `start` re-initialises it.
- Latency: `req` sampled high in IDLE at edge 0 gives LOAD_A at cycle 1 and LOAD_B at cycle 2. WAIT runs cycles 3..MUL_CYCLES+2. RESP (`done`) is at cycle MUL_CYCLES+3.
- Back-to-back: next grant is 1 cycle after RESP. Throughput is one job per MUL_CYCLES+4 cycles.
- `gnt`, `done`, `busy`, `mul_*` are registered or pure decodes of registered state. No combinational path from `req` to any output.
- `prod` updates only on the WAIT→RESP edge.

## Structure
- Package `booth_sched_pkg`: state enum (IDLE..RESP), default W, MUL_CYCLES, and a `CNT_W` = clog2(MUL_CYCLES) helper.
- Sub-module `rr_arbiter`: combinational. Inputs are `req` and `rr_ptr`. Outputs are a one-hot `win` and an index. The scheduler holds the FSM, operand and index registers, `cnt` and `prod`.

## Test plan
- Single job: `req[0]`=1, `op_a[0]`=-10, `op_b[0]`=13 → `mul_data`=0xFFF6 then 0x000D, `done[0]` at cycle MUL_CYCLES+3, `prod`=0xFFFFFF7E (-130).
- Simultaneous requests after reset: req0 (3×4) and req1 (-7×-9) → req0 served first with `prod`=12, then req1 with `prod`=63. `gnt` is one-hot throughout.
- Fairness: req0 and req1 both held high for 4 jobs → grant order is 0,1,0,1.
- Corner operands: -32768 × -32768 → `prod`=0x40000000. 32767 × -32768 → 0xC0008000.
- Reset mid-WAIT: assert `rst_n`=0 at cycle 8 of a job → all outputs are 0 immediately and no `done`. After release, a new req1 is served with a correct product.
- Operand change after grant: alter `op_a[0]` during WAIT → `prod` reflects the operands latched at grant.
